// File: rtl/sd_reg_bank_pkg.sv
// Shared types and constants for the SD host register bank: access-type
// codes, handshake FSM states, SD register indices and the default masks
// for the SD register map.
package sd_reg_bank_pkg;

  // Who owns a word and how host writes affect it.
  typedef enum logic [1:0] {
    ACC_RW  = 2'd0,  // host-owned, byte-enabled writes
    ACC_RO  = 2'd1,  // hardware-owned, loaded via hw_ld
    ACC_W1C = 2'd2   // status: hardware sets, host writes 1 to clear
  } acc_t;

  // Host handshake FSM states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  // SD register indices. Index 1 is the normal interrupt enable word,
  // which the bank uses as its default interrupt enable.
  localparam int REG_NISR    = 0;
  localparam int REG_PSR     = 2;
  localparam int REG_EISR    = 3;
  localparam int REG_TMR     = 4;
  localparam int REG_BCR     = 5;
  localparam int REG_BSR     = 6;
  localparam int REG_CR      = 7;
  localparam int REG_BGCR    = 8;
  localparam int REG_ARG     = 9;
  localparam int REG_RESP    = 10;
  localparam int REG_ADMASAR = 11;

  // Default masks for the SD map: present state and response are
  // hardware-owned; the two interrupt status words are W1C.
  localparam logic [15:0] SD_RO_MASK  = 16'h0404;
  localparam logic [15:0] SD_W1C_MASK = 16'h0009;

  // Resolve a word's access type from its RO / W1C mask bits.
  function automatic acc_t acc_of(input logic is_ro, input logic is_w1c);
    if (is_ro)       return ACC_RO;
    else if (is_w1c) return ACC_W1C;
    else             return ACC_RW;
  endfunction

endpackage

// File: rtl/sd_reg_bank_cell.sv
// One DATA_W register word whose update rule is fixed by its access type.
// The host write arrives already byte-masked (wmask); nxt exposes the
// post-update value so the top level can register the interrupt from it.
module sd_reg_bank_cell
  import sd_reg_bank_pkg::*;
#(
  parameter int   DATA_W = 32,
  parameter acc_t ACC    = ACC_RW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wmask,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] set,
  input  logic              ld,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] nxt
);

  // Next-value rule per access type; inputs that do not apply are ignored.
  always_comb begin
    nxt = q;
    case (ACC)
      ACC_RW: begin
        if (wr_en) nxt = (q & ~wmask) | (wdata & wmask);
      end
      ACC_RO: begin
        if (ld) nxt = ld_data;
      end
      default: begin
        // Set is ORed in after the clear so it wins on a collision.
        nxt = (q & ~(wr_en ? (wdata & wmask) : '0)) | set;
      end
    endcase
  end

  // Word storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= nxt;
  end

endmodule

// File: rtl/sd_reg_bank.sv
// SD host register bank: N_REGS words of RW / RO / W1C type behind a
// req/ack host port, with hardware set/load inputs and a registered
// interrupt from the status and enable words.
//
// Handshake: the host raises req with we/addr/wdata/be stable and holds it
// until ack. The bank samples and performs the access on the first edge
// req is seen in IDLE, then pulses ack for exactly one cycle with rdata
// (pre-update word value) and err. req seen during the ACK cycle is not a
// new request, so held-high req completes one access every two cycles.
module sd_reg_bank
  import sd_reg_bank_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                N_REGS   = 16,
  parameter logic [N_REGS-1:0] RO_MASK  = '0,
  parameter logic [N_REGS-1:0] W1C_MASK = '0,
  parameter int                INT_STAT = 0,
  parameter int                INT_EN   = 1,
  localparam int               ADDR_W   = $clog2(N_REGS),
  localparam int               BE_W     = DATA_W / 8
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     req,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [BE_W-1:0]          be,
  output logic                     ack,
  output logic [DATA_W-1:0]        rdata,
  output logic                     err,
  input  logic [N_REGS*DATA_W-1:0] hw_set,
  input  logic [N_REGS-1:0]        hw_ld,
  input  logic [N_REGS*DATA_W-1:0] hw_ld_data,
  output logic [N_REGS*DATA_W-1:0] regs_q,
  output logic                     irq
);

  state_t              state_q, state_d;
  logic                access;
  logic [DATA_W-1:0]   wmask;
  logic [DATA_W-1:0]   q_w   [N_REGS];
  logic [DATA_W-1:0]   nxt_w [N_REGS];
  logic [N_REGS-1:0]   wr_sel;
  logic [DATA_W-1:0]   rd_word;
  logic                in_range;
  logic                ro_hit;
  logic                err_d;

  // Expand byte enables into a per-bit write mask.
  for (genvar k = 0; k < BE_W; k++) begin : g_mask
    assign wmask[8*k +: 8] = {8{be[k]}};
  end

  // Handshake state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state; an access is performed on the edge that leaves IDLE.
  always_comb begin
    state_d = state_q;
    access  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          access  = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign ack = (state_q == ST_ACK);

  // Address decode: write select, read mux, range and RO detection.
  always_comb begin
    rd_word  = '0;
    ro_hit   = 1'b0;
    in_range = 1'b0;
    wr_sel   = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (addr == ADDR_W'(i)) begin
        rd_word   = q_w[i];
        ro_hit    = RO_MASK[i];
        in_range  = 1'b1;
        wr_sel[i] = access & we;
      end
    end
    err_d = ~in_range | (we & ro_hit);
  end

  for (genvar i = 0; i < N_REGS; i++) begin : g_cell
    sd_reg_bank_cell #(
      .DATA_W (DATA_W),
      .ACC    (acc_of(RO_MASK[i], W1C_MASK[i]))
    ) u_cell (
      .clk     (CLK),
      .rst     (RESET),
      .wr_en   (wr_sel[i]),
      .wmask   (wmask),
      .wdata   (wdata),
      .set     (hw_set[i*DATA_W +: DATA_W]),
      .ld      (hw_ld[i]),
      .ld_data (hw_ld_data[i*DATA_W +: DATA_W]),
      .q       (q_w[i]),
      .nxt     (nxt_w[i])
    );
    assign regs_q[i*DATA_W +: DATA_W] = q_w[i];
  end

  // Response data: captured on the access edge, zero outside the ACK cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rdata <= '0;
      err   <= 1'b0;
    end else if (access) begin
      rdata <= in_range ? rd_word : '0;
      err   <= err_d;
    end else begin
      rdata <= '0;
      err   <= 1'b0;
    end
  end

  // Interrupt registered from the post-update status and enable words.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) irq <= 1'b0;
    else       irq <= |(nxt_w[INT_STAT] & nxt_w[INT_EN]);
  end

endmodule

// File: tb/tb_sd_reg_bank.sv
// Self-checking bench for sd_reg_bank built with N_REGS=17 so that
// out-of-range addresses exist. Word 0 is W1C status, word 1 is the
// interrupt enable, word 2 is RO.
module tb_sd_reg_bank;

  localparam int DW = 32;
  localparam int NR = 17;
  localparam int AW = 5;
  localparam int BW = 4;
  localparam logic [NR-1:0] RO_M  = 17'h00004;
  localparam logic [NR-1:0] W1C_M = 17'h00001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              req, we, ack, err, irq;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     wdata, rdata;
  logic [BW-1:0]     be;
  logic [NR*DW-1:0]  hw_set, hw_ld_data, regs_q;
  logic [NR-1:0]     hw_ld;

  sd_reg_bank #(
    .DATA_W   (DW),
    .N_REGS   (NR),
    .RO_MASK  (RO_M),
    .W1C_MASK (W1C_M),
    .INT_STAT (0),
    .INT_EN   (1)
  ) dut (
    .CLK        (clk),
    .RESET      (rst),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .be         (be),
    .ack        (ack),
    .rdata      (rdata),
    .err        (err),
    .hw_set     (hw_set),
    .hw_ld      (hw_ld),
    .hw_ld_data (hw_ld_data),
    .regs_q     (regs_q),
    .irq        (irq)
  );

  int checks   = 0;
  int failures = 0;
  int ack_cycles = 0;

  always @(negedge clk) if (ack === 1'b1) ack_cycles++;

  // ---------------- reference model ----------------
  // Word array plus the expected response of the access sampled at each edge.
  logic [DW-1:0] m [NR];
  logic          m_busy, m_ack, m_err, m_irq;
  logic [DW-1:0] m_rdata;

  always @(posedge clk or posedge rst) begin : model
    logic [DW-1:0] nx [NR];
    logic [DW-1:0] bm, clr;
    logic          acc, hit;
    if (rst) begin
      for (int i = 0; i < NR; i++) m[i] = '0;
      m_busy = 0; m_ack = 0; m_err = 0; m_irq = 0; m_rdata = '0;
    end else begin
      acc = req && !m_busy;
      for (int k = 0; k < BW; k++) bm[8*k +: 8] = {8{be[k]}};
      for (int i = 0; i < NR; i++) begin
        nx[i] = m[i];
        hit = acc && we && (int'(addr) == i);
        if (W1C_M[i]) begin
          clr = hit ? (wdata & bm) : '0;
          nx[i] = (m[i] & ~clr) | hw_set[i*DW +: DW];
        end else if (RO_M[i]) begin
          if (hw_ld[i]) nx[i] = hw_ld_data[i*DW +: DW];
        end else if (hit) begin
          nx[i] = (m[i] & ~bm) | (wdata & bm);
        end
      end
      m_ack   = acc;
      m_rdata = (acc && int'(addr) < NR) ? m[addr] : '0;
      m_err   = acc && ((int'(addr) >= NR) || (we && RO_M[addr]));
      m_irq   = |(nx[0] & nx[1]);
      m_busy  = acc;
      for (int i = 0; i < NR; i++) m[i] = nx[i];
    end
  end

  // ---------------- driver ----------------
  // One host access; lat = cycles from driving req to seeing ack (0 = none).
  task automatic bus(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [BW-1:0] b, output int lat,
                     output logic [DW-1:0] rd, output logic er);
    @(posedge clk); #1;
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    lat = 0; rd = '0; er = 1'b0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin
        lat = c; rd = rdata; er = err;
      end
    end
    req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int a0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (regs_q !== '0) begin failures++; $display("FAIL reset_regs got=%h exp=0", regs_q); end
    checks++; if ({ack, err, irq} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {ack, err, irq}); end
    checks++; if (rdata !== '0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    // Request pending, then reset lands before it can complete.
    req = 1'b1; we = 1'b1; addr = 5'd1; wdata = 32'hFFFF_FFFF; be = 4'hF;
    @(negedge clk) rst = 1'b1;
    a0 = ack_cycles;
    repeat (2) @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ack_cycles !== a0) begin failures++; $display("FAIL reset_no_ack got=%0d exp=%0d", ack_cycles, a0); end
    checks++; if (regs_q !== '0) begin failures++; $display("FAIL reset_mid_regs got=%h exp=0", regs_q); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
  endtask

  task automatic test_rw_be();
    int lat; logic [DW-1:0] rd; logic er;
    bus(1'b1, 5'd1, 32'hDEAD_BEEF, 4'b0101, lat, rd, er);
    checks++; if (lat !== 1) begin failures++; $display("FAIL rw_latency got=%0d exp=1", lat); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL rw_err got=%b exp=0", er); end
    checks++; if (regs_q[1*DW +: DW] !== 32'h00AD_00EF) begin failures++; $display("FAIL rw_word got=%h exp=00ad00ef", regs_q[1*DW +: DW]); end
    @(posedge clk); #1;
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL ack_one_cycle got=%b exp=0", ack); end
    checks++; if (rdata !== '0) begin failures++; $display("FAIL rdata_idle got=%h exp=0", rdata); end
    bus(1'b0, 5'd1, 32'h0, 4'h0, lat, rd, er);
    checks++; if (rd !== 32'h00AD_00EF) begin failures++; $display("FAIL rw_read got=%h exp=00ad00ef", rd); end
  endtask

  task automatic test_w1c_irq();
    int lat; logic [DW-1:0] rd; logic er;
    bus(1'b1, 5'd1, 32'h2, 4'hF, lat, rd, er);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_idle got=%b exp=0", irq); end
    @(posedge clk); #1 hw_set[0 +: DW] = 32'h0000_0012;
    @(posedge clk); #1 hw_set = '0;
    checks++; if (regs_q[0 +: DW] !== 32'h12) begin failures++; $display("FAIL w1c_set got=%h exp=12", regs_q[0 +: DW]); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_rise got=%b exp=1", irq); end
    bus(1'b1, 5'd0, 32'h2, 4'hF, lat, rd, er);
    checks++; if (regs_q[0 +: DW] !== 32'h10) begin failures++; $display("FAIL w1c_clear got=%h exp=10", regs_q[0 +: DW]); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_fall got=%b exp=0", irq); end
    checks++; if (rd !== 32'h12) begin failures++; $display("FAIL w1c_preupdate got=%h exp=12", rd); end
  endtask

  task automatic test_collision();
    int lat; logic [DW-1:0] rd; logic er;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = 5'd0; wdata = 32'h10; be = 4'hF;
    hw_set[0 +: DW] = 32'h10;
    @(posedge clk); #1;
    hw_set = '0;
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL coll_ack got=%b exp=1", ack); end
    checks++; if (regs_q[4] !== 1'b1) begin failures++; $display("FAIL coll_set_wins got=%b exp=1", regs_q[4]); end
    req = 1'b0;
    bus(1'b1, 5'd0, 32'h10, 4'hF, lat, rd, er);
    checks++; if (regs_q[0 +: DW] !== 32'h0) begin failures++; $display("FAIL w1c_clear2 got=%h exp=0", regs_q[0 +: DW]); end
    // Clear limited by byte enables.
    @(posedge clk); #1 hw_set[0 +: DW] = 32'h0101_0101;
    @(posedge clk); #1 hw_set = '0;
    bus(1'b1, 5'd0, 32'hFFFF_FFFF, 4'b0001, lat, rd, er);
    checks++; if (regs_q[0 +: DW] !== 32'h0101_0100) begin failures++; $display("FAIL w1c_be got=%h exp=01010100", regs_q[0 +: DW]); end
  endtask

  task automatic test_ro();
    int lat; logic [DW-1:0] rd; logic er; logic [DW-1:0] w1;
    bus(1'b1, 5'd2, 32'hFFFF_FFFF, 4'hF, lat, rd, er);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL ro_write_err got=%b exp=1", er); end
    checks++; if (regs_q[2*DW +: DW] !== 32'h0) begin failures++; $display("FAIL ro_unchanged got=%h exp=0", regs_q[2*DW +: DW]); end
    w1 = regs_q[1*DW +: DW];
    @(posedge clk); #1;
    hw_ld[2] = 1'b1; hw_ld_data[2*DW +: DW] = 32'h1234_5678;
    hw_ld[1] = 1'b1; hw_ld_data[1*DW +: DW] = 32'hFFFF_0000;
    hw_set[1*DW +: DW] = 32'h0000_FFFF;
    @(posedge clk); #1;
    hw_ld = '0; hw_ld_data = '0; hw_set = '0;
    checks++; if (regs_q[1*DW +: DW] !== w1) begin failures++; $display("FAIL rw_ignores_hw got=%h exp=%h", regs_q[1*DW +: DW], w1); end
    bus(1'b0, 5'd2, 32'h0, 4'h0, lat, rd, er);
    checks++; if (rd !== 32'h1234_5678) begin failures++; $display("FAIL ro_load got=%h exp=12345678", rd); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL ro_read_err got=%b exp=0", er); end
  endtask

  task automatic test_range();
    int lat; logic [DW-1:0] rd; logic er; logic [NR*DW-1:0] snap;
    bus(1'b0, 5'd17, 32'h0, 4'h0, lat, rd, er);
    checks++; if ({er, rd} !== {1'b1, 32'h0}) begin failures++; $display("FAIL oor_read got=%b/%h exp=1/0", er, rd); end
    snap = regs_q;
    bus(1'b1, 5'd20, 32'hFFFF_FFFF, 4'hF, lat, rd, er);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL oor_write_err got=%b exp=1", er); end
    checks++; if (regs_q !== snap) begin failures++; $display("FAIL oor_write_dropped got=%h exp=%h", regs_q, snap); end
    bus(1'b1, 5'd16, 32'hA5A5_5A5A, 4'hF, lat, rd, er);
    checks++; if ({er, regs_q[16*DW +: DW]} !== {1'b0, 32'hA5A5_5A5A}) begin failures++; $display("FAIL last_word got=%b/%h exp=0/a5a55a5a", er, regs_q[16*DW +: DW]); end
  endtask

  task automatic test_back_to_back();
    int n_ack = 0;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; addr = 5'd16; wdata = '0; be = '0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      checks++; if (ack !== logic'(c % 2)) begin failures++; $display("FAIL b2b_ack c=%0d got=%b exp=%0d", c, ack, c % 2); end
      if (ack === 1'b1) begin
        n_ack++;
        checks++; if (rdata !== 32'hA5A5_5A5A) begin failures++; $display("FAIL b2b_rdata got=%h exp=a5a55a5a", rdata); end
      end
    end
    req = 1'b0;
    checks++; if (n_ack !== 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", n_ack); end
  endtask

  task automatic test_random();
    int lat; logic [DW-1:0] rd; logic er; logic [NR*DW-1:0] exp_flat;
    for (int n = 0; n < 150; n++) begin
      for (int i = 0; i < NR; i++) begin
        hw_set[i*DW +: DW]     = $urandom & $urandom & $urandom;
        hw_ld_data[i*DW +: DW] = $urandom;
      end
      hw_ld = NR'($urandom);
      bus(1'($urandom_range(0, 1)), AW'($urandom_range(0, 20)), $urandom,
          BW'($urandom), lat, rd, er);
      hw_set = '0; hw_ld = '0;
      for (int i = 0; i < NR; i++) exp_flat[i*DW +: DW] = m[i];
      checks++; if (lat !== 1) begin failures++; $display("FAIL rnd_lat n=%0d got=%0d exp=1", n, lat); end
      checks++; if (rd !== m_rdata) begin failures++; $display("FAIL rnd_rdata n=%0d got=%h exp=%h", n, rd, m_rdata); end
      checks++; if (er !== m_err) begin failures++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, er, m_err); end
      checks++; if (irq !== m_irq) begin failures++; $display("FAIL rnd_irq n=%0d got=%b exp=%b", n, irq, m_irq); end
      checks++; if (regs_q !== exp_flat) begin failures++; $display("FAIL rnd_regs n=%0d got=%h exp=%h", n, regs_q, exp_flat); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    hw_set = '0; hw_ld = '0; hw_ld_data = '0;
    test_reset();
    test_rw_be();
    test_w1c_irq();
    test_collision();
    test_ro();
    test_range();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
